// File: rtl/regfile_dbg_pkg.sv
// Shared definitions for the register-file debug arbiter: widths, FSM state
// encoding, response error codes and the x0 write-suppression helper.
package regfile_dbg_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    localparam logic [2:0] ST_RUN     = 3'd0;
    localparam logic [2:0] ST_DRAIN   = 3'd1;
    localparam logic [2:0] ST_GRANT   = 3'd2;
    localparam logic [2:0] ST_ACCESS  = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;
    localparam logic [2:0] ST_RELEASE = 3'd5;

    localparam logic RSP_ERR_NONE        = 1'b0;
    localparam logic RSP_ERR_UNSUPPORTED = 1'b1;

    // x0 is hardwired to zero, so no write may ever target it.
    function automatic logic is_writable(input logic [REG_AW-1:0] addr);
        return (addr != {REG_AW{1'b0}});
    endfunction

endpackage

// File: rtl/regfile_dbg_arbiter.sv
// Arbitrates the register-file write port and debug read port between CPU
// writeback and a debug host. Debug reads are served only when REGFILE_DBG_READ_EN is defined.
module regfile_dbg_arbiter
    import regfile_dbg_pkg::*;
#(
    parameter int DRAIN_CYCLES = 1,
    parameter int MAX_HOLD     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_regWrite,
    input  logic [REG_AW-1:0] cpu_rd,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic              dbg_req_write,
    input  logic [REG_AW-1:0] dbg_req_addr,
    input  logic [DATA_W-1:0] dbg_req_wdata,
    output logic              dbg_rsp_valid,
    input  logic              dbg_rsp_ready,
    output logic [DATA_W-1:0] dbg_rsp_data,
    output logic              dbg_rsp_err,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [REG_AW-1:0] rf_dbg_raddr,
    input  logic [DATA_W-1:0] rf_dbg_rdata
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int HOLD_W  = $clog2(MAX_HOLD + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LIMIT = HOLD_W'(MAX_HOLD);

    logic [2:0]         state_q,     state_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [HOLD_W-1:0]  hold_cnt_q,  hold_cnt_d;
    logic               cap_write_q, cap_write_d;
    logic [REG_AW-1:0]  cap_addr_q,  cap_addr_d;
    logic [DATA_W-1:0]  cap_wdata_q, cap_wdata_d;
    logic [DATA_W-1:0]  rsp_data_q,  rsp_data_d;
    logic               rsp_err_q,   rsp_err_d;

    logic               req_hs_s;
    logic [DATA_W-1:0]  rd_data_s;
    logic               rd_err_s;

    assign req_hs_s = dbg_req_valid && dbg_req_ready;

`ifdef REGFILE_DBG_READ_EN
    assign rd_data_s = rf_dbg_rdata;
    assign rd_err_s  = RSP_ERR_NONE;
`else
    logic rdata_unused_s;
    assign rdata_unused_s = ^rf_dbg_rdata;
    assign rd_data_s      = {DATA_W{1'b0}};
    assign rd_err_s       = RSP_ERR_UNSUPPORTED;
`endif

    // Next-state logic: window sequencing, drain/hold counters, request capture and response latch.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        cap_write_d = cap_write_q;
        cap_addr_d  = cap_addr_q;
        cap_wdata_d = cap_wdata_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_RUN: begin
                if (dbg_req_valid) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = {DRAIN_W{1'b0}};
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d     = ST_GRANT;
                    drain_cnt_d = {DRAIN_W{1'b0}};
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end
            ST_GRANT: begin
                // A withdrawn request ends the window rather than holding the CPU.
                if (!dbg_req_valid) begin
                    state_d = ST_RELEASE;
                end else if (req_hs_s) begin
                    state_d     = ST_ACCESS;
                    cap_write_d = dbg_req_write;
                    cap_addr_d  = dbg_req_addr;
                    cap_wdata_d = dbg_req_wdata;
                    hold_cnt_d  = hold_cnt_q + HOLD_W'(1);
                end else begin
                    state_d = ST_GRANT;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                if (cap_write_q) begin
                    rsp_data_d = {DATA_W{1'b0}};
                    rsp_err_d  = RSP_ERR_NONE;
                end else begin
                    rsp_data_d = rd_data_s;
                    rsp_err_d  = rd_err_s;
                end
            end
            ST_RESP: begin
                if (!dbg_rsp_ready) begin
                    state_d = ST_RESP;
                end else if (dbg_req_valid && (hold_cnt_q < HOLD_LIMIT)) begin
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d    = ST_RUN;
                hold_cnt_d = {HOLD_W{1'b0}};
            end
            default: begin
                state_d     = ST_RUN;
                drain_cnt_d = {DRAIN_W{1'b0}};
                hold_cnt_d  = {HOLD_W{1'b0}};
            end
        endcase
    end

    // State and capture registers; reset aborts any window immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= {DRAIN_W{1'b0}};
            hold_cnt_q  <= {HOLD_W{1'b0}};
            cap_write_q <= 1'b0;
            cap_addr_q  <= {REG_AW{1'b0}};
            cap_wdata_q <= {DATA_W{1'b0}};
            rsp_data_q  <= {DATA_W{1'b0}};
            rsp_err_q   <= RSP_ERR_NONE;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            cap_write_q <= cap_write_d;
            cap_addr_q  <= cap_addr_d;
            cap_wdata_q <= cap_wdata_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Output decode: CPU owns the write port except during a debug write access.
    always_comb begin
        cpu_stall     = 1'b0;
        dbg_req_ready = 1'b0;
        dbg_rsp_valid = 1'b0;
        dbg_rsp_data  = {DATA_W{1'b0}};
        dbg_rsp_err   = RSP_ERR_NONE;
        rf_we         = cpu_regWrite && is_writable(cpu_rd);
        rf_waddr      = cpu_rd;
        rf_wdata      = cpu_wdata;
        rf_dbg_raddr  = {REG_AW{1'b0}};
        case (state_q)
            ST_RUN: begin
                cpu_stall = 1'b0;
            end
            ST_DRAIN: begin
                cpu_stall = 1'b1;
            end
            ST_GRANT: begin
                cpu_stall     = 1'b1;
                dbg_req_ready = !cpu_regWrite;
            end
            ST_ACCESS: begin
                cpu_stall = 1'b1;
                if (cap_write_q) begin
                    rf_we    = is_writable(cap_addr_q);
                    rf_waddr = cap_addr_q;
                    rf_wdata = cap_wdata_q;
                end else begin
`ifdef REGFILE_DBG_READ_EN
                    rf_dbg_raddr = cap_addr_q;
`else
                    rf_dbg_raddr = {REG_AW{1'b0}};
`endif
                end
            end
            ST_RESP: begin
                cpu_stall     = 1'b1;
                dbg_rsp_valid = 1'b1;
                dbg_rsp_data  = rsp_data_q;
                dbg_rsp_err   = rsp_err_q;
            end
            ST_RELEASE: begin
                cpu_stall = 1'b0;
            end
            default: begin
                cpu_stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_dbg_arbiter.sv
// Directed bench for regfile_dbg_arbiter with a register-file model and a
// response scoreboard; expectations follow REGFILE_DBG_READ_EN when defined.
module tb_regfile_dbg_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_regWrite;
    logic [4:0]  cpu_rd;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic        dbg_req_valid;
    logic        dbg_req_ready;
    logic        dbg_req_write;
    logic [4:0]  dbg_req_addr;
    logic [31:0] dbg_req_wdata;
    logic        dbg_rsp_valid;
    logic        dbg_rsp_ready;
    logic [31:0] dbg_rsp_data;
    logic        dbg_rsp_err;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rf_dbg_raddr;
    logic [31:0] rf_dbg_rdata;

    logic [31:0] rf_mem [32];
    logic [32:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          rsp_cnt = 0;
    int          stall_falls = 0;
    int          rsp_at_first_fall = -1;
    logic        prev_stall = 1'b0;

    regfile_dbg_arbiter #(.DRAIN_CYCLES(1), .MAX_HOLD(16)) dut (
        .clk(clk), .rst(rst),
        .cpu_regWrite(cpu_regWrite), .cpu_rd(cpu_rd), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
        .dbg_req_write(dbg_req_write), .dbg_req_addr(dbg_req_addr),
        .dbg_req_wdata(dbg_req_wdata),
        .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
        .dbg_rsp_data(dbg_rsp_data), .dbg_rsp_err(dbg_rsp_err),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_dbg_raddr(rf_dbg_raddr), .rf_dbg_rdata(rf_dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: synchronous write, combinational debug read.
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    end
    assign rf_dbg_rdata = rf_mem[rf_dbg_raddr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every consumed response is popped and compared.
    always @(negedge clk) begin
        if (rst && dbg_rsp_valid && dbg_rsp_ready) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("rsp_data", dbg_rsp_data, e[32:1]);
                chk("rsp_err", {31'd0, dbg_rsp_err}, {31'd0, e[0]});
            end
        end
    end

    // Window tracker: remembers how many responses preceded the first stall release.
    always @(negedge clk) begin
        if (prev_stall && !cpu_stall) begin
            stall_falls++;
            if (rsp_at_first_fall < 0) rsp_at_first_fall = rsp_cnt;
        end
        prev_stall = cpu_stall;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic [31:0] ed, input logic ee, input bit expect_rsp, input bit keep);
        int n;
        n = 0;
        dbg_req_valid = 1'b1;
        dbg_req_write = w;
        dbg_req_addr  = a;
        dbg_req_wdata = d;
        @(negedge clk);
        while (!dbg_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready", {31'd0, dbg_req_ready}, 32'd1);
        if (expect_rsp) exp_q.push_back({ed, ee});
        @(posedge clk);
        #1;
        if (!keep) dbg_req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] rd_exp_data;
        logic        rd_exp_err;
        int          base;
        int          n;
`ifdef REGFILE_DBG_READ_EN
        rd_exp_data = 32'hDEADBEEF;
        rd_exp_err  = 1'b0;
`else
        rd_exp_data = 32'h0;
        rd_exp_err  = 1'b1;
`endif
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
        rst = 1'b0;
        cpu_regWrite = 1'b0; cpu_rd = 5'd0; cpu_wdata = 32'h0;
        dbg_req_valid = 1'b0; dbg_req_write = 1'b0; dbg_req_addr = 5'd0; dbg_req_wdata = 32'h0;
        dbg_rsp_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_ready", {31'd0, dbg_req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, dbg_rsp_valid}, 32'd0);
        chk("rst_rsp_data", dbg_rsp_data, 32'd0);
        chk("rst_rsp_err", {31'd0, dbg_rsp_err}, 32'd0);
        chk("rst_raddr", {27'd0, rf_dbg_raddr}, 32'd0);
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        step();
        rst = 1'b1;
        step();

        // CPU writeback with no debug traffic
        cpu_regWrite = 1'b1; cpu_rd = 5'd5; cpu_wdata = 32'h1234;
        @(negedge clk);
        chk("cpu_we", {31'd0, rf_we}, 32'd1);
        chk("cpu_waddr", {27'd0, rf_waddr}, 32'd5);
        chk("cpu_wdata", rf_wdata, 32'h1234);
        chk("cpu_no_stall", {31'd0, cpu_stall}, 32'd0);
        step();
        cpu_regWrite = 1'b0;
        step();
        chk("x5_written", rf_mem[5], 32'h1234);

        // Debug write x7: stall T+1, ready T+2, write T+3, response T+4
        dbg_req_valid = 1'b1; dbg_req_write = 1'b1; dbg_req_addr = 5'd7; dbg_req_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("T_stall", {31'd0, cpu_stall}, 32'd0);
        step();
        @(negedge clk);
        chk("T1_stall", {31'd0, cpu_stall}, 32'd1);
        chk("T1_ready", {31'd0, dbg_req_ready}, 32'd0);
        step();
        @(negedge clk);
        chk("T2_ready", {31'd0, dbg_req_ready}, 32'd1);
        exp_q.push_back({32'h0, 1'b0});
        step();
        dbg_req_valid = 1'b0;
        @(negedge clk);
        chk("T3_we", {31'd0, rf_we}, 32'd1);
        chk("T3_waddr", {27'd0, rf_waddr}, 32'd7);
        chk("T3_wdata", rf_wdata, 32'hDEADBEEF);
        chk("T3_rsp_valid", {31'd0, dbg_rsp_valid}, 32'd0);
        step();
        @(negedge clk);
        chk("T4_rsp_valid", {31'd0, dbg_rsp_valid}, 32'd1);
        chk("x7_written", rf_mem[7], 32'hDEADBEEF);
        repeat (4) step();

        // Debug read x7 with a stalled consumer: response must hold
        dbg_rsp_ready = 1'b0;
        send(1'b0, 5'd7, 32'h0, rd_exp_data, rd_exp_err, 1'b1, 1'b0);
`ifdef REGFILE_DBG_READ_EN
        chk("rd_raddr", {27'd0, rf_dbg_raddr}, 32'd7);
`else
        chk("rd_raddr", {27'd0, rf_dbg_raddr}, 32'd0);
`endif
        repeat (3) step();
        @(negedge clk);
        chk("rd_hold_valid", {31'd0, dbg_rsp_valid}, 32'd1);
        chk("rd_hold_data", dbg_rsp_data, rd_exp_data);
        dbg_rsp_ready = 1'b1;
        repeat (4) step();

        // Debug write to x0 is suppressed but still answered
        send(1'b1, 5'd0, 32'hABCD, 32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("x0_we", {31'd0, rf_we}, 32'd0);
        repeat (4) step();
        chk("x0_zero", rf_mem[0], 32'h0);

        // 20 back-to-back writes: 16 in the first window, 4 in the next
        base = rsp_cnt;
        stall_falls = 0;
        rsp_at_first_fall = -1;
        for (int i = 0; i < 20; i++) begin
            send(1'b1, 5'(i + 1), 32'h1000 + i, 32'h0, 1'b0, 1'b1, (i < 19));
        end
        repeat (6) step();
        chk("burst_first_window", rsp_at_first_fall - base, 32'd16);
        chk("burst_total", rsp_cnt - base, 32'd20);
        chk("burst_windows", stall_falls, 32'd2);
        chk("burst_x20", rf_mem[20], 32'h1013);

        // Reset during ACCESS of a write to x9
        cpu_regWrite = 1'b1; cpu_rd = 5'd9; cpu_wdata = 32'h55;
        step();
        cpu_regWrite = 1'b0;
        step();
        base = rsp_cnt;
        send(1'b1, 5'd9, 32'hBAD0BAD0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("abort_stall", {31'd0, cpu_stall}, 32'd0);
        chk("abort_we", {31'd0, rf_we}, 32'd0);
        @(negedge clk);
        chk("abort_rsp_valid", {31'd0, dbg_rsp_valid}, 32'd0);
        chk("abort_ready", {31'd0, dbg_req_ready}, 32'd0);
        chk("abort_raddr", {27'd0, rf_dbg_raddr}, 32'd0);
        step();
        rst = 1'b1;
        repeat (4) step();
        chk("abort_x9", rf_mem[9], 32'h55);
        chk("abort_no_rsp", rsp_cnt - base, 32'd0);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
